seq_onehot_encoder: RTL and testbench

Sequential 8-to-3 encoder: the reverse of the team's 3-to-8 select decoder. It accepts an 8-bit request vector with any number of bits set and emits the 3-bit index of every set bit, one per output handshake, in a fixed priority order. It sits between request-collecting logic (interrupt and event lines) and any consumer that takes a binary select. Downstream, the decoder regenerates the one-hot form.

---
 rtl/enc_pkg.sv | 10 +
 rtl/prio_enc8.sv | 35 +++
 rtl/seq_onehot_encoder.sv | 96 +++++++++
 tb/tb_seq_onehot_encoder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared widths and state encoding for the sequential 8-to-3 encoder.
package enc_pkg;
  localparam int VEC_W = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_t;
endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-bit priority encoder: index of the lowest (or highest) set bit,
// plus flags for "any bit set" and "exactly one bit set".
module prio_enc8
  import enc_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  input  logic             msb_first,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             single
);

  // Priority selection: the last match in scan order wins.
  always_comb begin
    idx = {IDX_W{1'b0}};
    if (msb_first) begin
      for (int i = 0; i < VEC_W; i++) begin
        if (vec[i]) begin
          idx = i[IDX_W-1:0];
        end
      end
    end else begin
      for (int i = VEC_W - 1; i >= 0; i--) begin
        if (vec[i]) begin
          idx = i[IDX_W-1:0];
        end
      end
    end
  end

  // Clearing the lowest set bit leaves zero only for a single-hot vector.
  assign any    = (vec != {VEC_W{1'b0}});
  assign single = any && ((vec & (vec - 8'd1)) == {VEC_W{1'b0}});

endmodule

// File: rtl/seq_onehot_encoder.sv
// Sequential 8-to-3 encoder: captures a multi-hot vector and emits the index of
// each set bit, one per output handshake, in fixed priority order.
module seq_onehot_encoder
  import enc_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             zero_err
);

  enc_state_t       state_q, state_d;
  logic [VEC_W-1:0] pend_q, pend_d;
  logic             zero_err_q, zero_err_d;

  logic [IDX_W-1:0] enc_idx_s;
  logic             enc_any_s;
  logic             enc_single_s;
  logic [VEC_W-1:0] clr_mask_s;

  prio_enc8 u_prio_enc8 (
    .vec       (pend_q),
    .msb_first (MSB_FIRST),
    .idx       (enc_idx_s),
    .any       (enc_any_s),
    .single    (enc_single_s)
  );

  assign clr_mask_s = ~({{(VEC_W-1){1'b0}}, 1'b1} << enc_idx_s);

  // Next-state, working-register and error-pulse logic.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    zero_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_vec != {VEC_W{1'b0}}) begin
            pend_d  = in_vec;
            state_d = EMIT;
          end else begin
            zero_err_d = 1'b1;
          end
        end else begin
          pend_d = pend_q;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (enc_single_s) begin
            pend_d  = {VEC_W{1'b0}};
            state_d = IDLE;
          end else begin
            pend_d = pend_q & clr_mask_s;
          end
        end else begin
          pend_d = pend_q;
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = {VEC_W{1'b0}};
      end
    endcase
  end

  // State, captured vector and zero-vector flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= {VEC_W{1'b0}};
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      zero_err_q <= zero_err_d;
    end
  end

  // Outputs derive from registers only, so no input-to-output combinational path exists.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_idx   = out_valid ? enc_idx_s : {IDX_W{1'b0}};
  assign out_last  = out_valid && enc_any_s && enc_single_s;
  assign zero_err  = zero_err_q;

endmodule

// File: tb/tb_seq_onehot_encoder.sv
// Directed bench for seq_onehot_encoder; an LSB-first and an MSB-first instance share stimulus.
module tb_seq_onehot_encoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_vec;
  logic       out_ready;

  logic       l_in_ready, l_out_valid, l_out_last, l_zero_err;
  logic [2:0] l_out_idx;
  logic       m_in_ready, m_out_valid, m_out_last, m_zero_err;
  logic [2:0] m_out_idx;

  int total;
  int bad;

  seq_onehot_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (l_in_ready),
    .in_vec    (in_vec),
    .out_valid (l_out_valid),
    .out_ready (out_ready),
    .out_idx   (l_out_idx),
    .out_last  (l_out_last),
    .zero_err  (l_zero_err)
  );

  seq_onehot_encoder #(.MSB_FIRST(1'b1)) dut_m (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (m_in_ready),
    .in_vec    (in_vec),
    .out_valid (m_out_valid),
    .out_ready (out_ready),
    .out_idx   (m_out_idx),
    .out_last  (m_out_last),
    .zero_err  (m_zero_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_vec = 8'h00; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (l_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", l_in_ready); end
    total++; if (l_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", l_out_valid); end
    total++; if (l_out_idx !== 3'd0) begin bad++; $display("FAIL reset_out_idx got=%0d exp=0", l_out_idx); end
    total++; if (l_out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b exp=0", l_out_last); end
    total++; if (l_zero_err !== 1'b0) begin bad++; $display("FAIL reset_zero_err got=%b exp=0", l_zero_err); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (l_in_ready !== 1'b1 || l_out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_idle in_ready=%b out_valid=%b exp=1/0", l_in_ready, l_out_valid); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_vec = 8'h10; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_vec = 8'h00;
    total++; if (l_out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", l_out_valid); end
    total++; if (l_out_idx !== 3'd4) begin bad++; $display("FAIL single_idx got=%0d exp=4", l_out_idx); end
    total++; if (l_out_last !== 1'b1) begin bad++; $display("FAIL single_last got=%b exp=1", l_out_last); end
    total++; if (l_in_ready !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", l_in_ready); end
    total++; if (m_out_idx !== 3'd4 || m_out_last !== 1'b1) begin bad++; $display("FAIL single_msb idx=%0d last=%b exp=4/1", m_out_idx, m_out_last); end
    @(negedge clk);
    total++; if (l_in_ready !== 1'b1 || l_out_valid !== 1'b0) begin bad++; $display("FAIL single_return in_ready=%b out_valid=%b exp=1/0", l_in_ready, l_out_valid); end
  endtask

  task automatic test_multi_hot();
    logic [2:0] exp_l [4];
    logic [2:0] exp_m [4];
    exp_l = '{3'd0, 3'd2, 3'd5, 3'd7};
    exp_m = '{3'd7, 3'd5, 3'd2, 3'd0};
    in_valid = 1'b1; in_vec = 8'hA5; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_vec = 8'h00;
    for (int k = 0; k < 4; k++) begin
      total++; if (l_out_valid !== 1'b1 || l_out_idx !== exp_l[k]) begin bad++; $display("FAIL multi_lsb beat=%0d valid=%b idx=%0d exp=1/%0d", k, l_out_valid, l_out_idx, exp_l[k]); end
      total++; if (l_out_last !== (k == 3)) begin bad++; $display("FAIL multi_lsb_last beat=%0d got=%b exp=%b", k, l_out_last, (k == 3)); end
      total++; if (m_out_valid !== 1'b1 || m_out_idx !== exp_m[k]) begin bad++; $display("FAIL multi_msb beat=%0d valid=%b idx=%0d exp=1/%0d", k, m_out_valid, m_out_idx, exp_m[k]); end
      total++; if (m_out_last !== (k == 3)) begin bad++; $display("FAIL multi_msb_last beat=%0d got=%b exp=%b", k, m_out_last, (k == 3)); end
      @(negedge clk);
    end
    total++; if (l_in_ready !== 1'b1 || m_in_ready !== 1'b1 || l_out_valid !== 1'b0) begin bad++; $display("FAIL multi_done in_ready=%b/%b out_valid=%b", l_in_ready, m_in_ready, l_out_valid); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_vec = 8'h03; out_ready = 1'b0;
    @(negedge clk);
    in_vec = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      total++; if (l_out_valid !== 1'b1 || l_out_idx !== 3'd0 || l_out_last !== 1'b0) begin bad++; $display("FAIL bp_hold cyc=%0d valid=%b idx=%0d last=%b exp=1/0/0", c, l_out_valid, l_out_idx, l_out_last); end
      total++; if (l_in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, l_in_ready); end
      if (c == 4) out_ready = 1'b1;
      @(negedge clk);
    end
    total++; if (l_out_idx !== 3'd1 || l_out_last !== 1'b1) begin bad++; $display("FAIL bp_second idx=%0d last=%b exp=1/1", l_out_idx, l_out_last); end
    in_valid = 1'b0; in_vec = 8'h00;
    @(negedge clk);
    total++; if (l_out_valid !== 1'b0 || l_in_ready !== 1'b1) begin bad++; $display("FAIL bp_no_accept out_valid=%b in_ready=%b exp=0/1", l_out_valid, l_in_ready); end
  endtask

  task automatic test_zero();
    in_valid = 1'b1; in_vec = 8'h00; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (l_zero_err !== 1'b1 || m_zero_err !== 1'b1) begin bad++; $display("FAIL zero_pulse got=%b/%b exp=1", l_zero_err, m_zero_err); end
    total++; if (l_out_valid !== 1'b0 || l_in_ready !== 1'b1) begin bad++; $display("FAIL zero_idle out_valid=%b in_ready=%b exp=0/1", l_out_valid, l_in_ready); end
    @(negedge clk);
    total++; if (l_zero_err !== 1'b0 || l_out_valid !== 1'b0) begin bad++; $display("FAIL zero_once zero_err=%b out_valid=%b exp=0/0", l_zero_err, l_out_valid); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_vec = 8'h5A; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_vec = 8'h00;
    total++; if (l_out_idx !== 3'd1) begin bad++; $display("FAIL mid_beat0 idx=%0d exp=1", l_out_idx); end
    @(negedge clk);
    total++; if (l_out_idx !== 3'd3) begin bad++; $display("FAIL mid_beat1 idx=%0d exp=3", l_out_idx); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (l_out_valid !== 1'b0 || l_out_idx !== 3'd0 || l_out_last !== 1'b0) begin bad++; $display("FAIL mid_reset_lsb valid=%b idx=%0d last=%b exp=0/0/0", l_out_valid, l_out_idx, l_out_last); end
    total++; if (m_out_valid !== 1'b0 || m_out_idx !== 3'd0 || m_out_last !== 1'b0) begin bad++; $display("FAIL mid_reset_msb valid=%b idx=%0d last=%b exp=0/0/0", m_out_valid, m_out_idx, m_out_last); end
    total++; if (l_in_ready !== 1'b1 || l_zero_err !== 1'b0) begin bad++; $display("FAIL mid_reset_ctl in_ready=%b zero_err=%b exp=1/0", l_in_ready, l_zero_err); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (l_out_valid !== 1'b0 || l_in_ready !== 1'b1) begin bad++; $display("FAIL mid_after cyc=%0d out_valid=%b in_ready=%b exp=0/1", c, l_out_valid, l_in_ready); end
    end
  endtask

  task automatic test_round_trip();
    logic [7:0] acc_l, acc_m, vec;
    int cnt;
    out_ready = 1'b1;
    for (int v = 0; v < 256; v++) begin
      vec = v[7:0];
      @(negedge clk);
      in_valid = 1'b1; in_vec = vec;
      @(negedge clk);
      in_valid = 1'b0; in_vec = ~vec;
      acc_l = 8'h00; acc_m = 8'h00; cnt = 0;
      for (int c = 0; c < 10; c++) begin
        if (!l_out_valid) break;
        acc_l = acc_l | (8'h01 << l_out_idx);
        acc_m = acc_m | (8'h01 << m_out_idx);
        cnt++;
        if (l_out_last) break;
        @(negedge clk);
      end
      total++; if (acc_l !== vec || acc_m !== vec || cnt != $countones(vec)) begin bad++; $display("FAIL round_trip vec=%h lsb=%h msb=%h beats=%0d exp=%h/%0d", vec, acc_l, acc_m, cnt, vec, $countones(vec)); end
    end
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_single();
    test_multi_hot();
    test_backpressure();
    test_zero();
    test_reset_mid();
    test_round_trip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
